// File: rtl/resp_checker.sv
// Golden-response checker: compares a streamed response vector sequence against a
// preloaded golden memory, accumulates error statistics and logs mismatches in a FIFO.
module resp_checker #(
    parameter int VEC_WIDTH  = 32,
    parameter int VEC_LENGTH = 1024,
    parameter int ADDR_W     = 10,
    parameter int LOG_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gold_we,
    input  logic [ADDR_W-1:0]    gold_addr,
    input  logic [VEC_WIDTH-1:0] gold_data,
    input  logic                 start,
    input  logic                 resp_valid,
    input  logic [VEC_WIDTH-1:0] resp_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [23:0]          bit_err_count,
    output logic [ADDR_W-1:0]    first_err_idx,
    output logic                 log_valid,
    output logic [ADDR_W-1:0]    log_idx,
    output logic [VEC_WIDTH-1:0] log_mask,
    input  logic                 log_ready,
    output logic                 log_overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int LOG_W = $clog2(LOG_DEPTH);
    localparam int PC_W  = $clog2(VEC_WIDTH + 1);
    localparam int ENT_W = ADDR_W + VEC_WIDTH;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VEC_LENGTH - 1);

    function automatic logic [PC_W-1:0] popcount(input logic [VEC_WIDTH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < VEC_WIDTH; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    // NOTE: memories carry no reset; golden contents must survive rst, and log
    // slots are only ever read behind the FIFO pointers.
    logic [VEC_WIDTH-1:0] gold_mem [VEC_LENGTH];
    logic [ENT_W-1:0]     log_mem  [LOG_DEPTH];

    logic [1:0]           state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0]    s1_idx_q, s1_idx_d;
    logic [VEC_WIDTH-1:0] s1_mask_q, s1_mask_d;
    logic [15:0]          err_count_q, err_count_d;
    logic [23:0]          bit_err_q, bit_err_d;
    logic [ADDR_W-1:0]    first_err_q, first_err_d;
    logic                 overflow_q, overflow_d;
    logic [LOG_W:0]       wr_ptr_q, wr_ptr_d;
    logic [LOG_W:0]       rd_ptr_q, rd_ptr_d;

    logic                 run_start;
    logic                 accept;
    logic                 s1_err;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 push;
    logic [24:0]          bit_sum;
    logic [ENT_W-1:0]     head;

    assign run_start  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign accept     = (state_q == ST_RUN) && resp_valid;
    assign s1_err     = s1_valid_q && (s1_mask_q != '0);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[LOG_W] != rd_ptr_q[LOG_W]) &&
                        (wr_ptr_q[LOG_W-1:0] == rd_ptr_q[LOG_W-1:0]);
    assign pop        = !fifo_empty && log_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = s1_err && (!fifo_full || pop);
    assign bit_sum    = {1'b0, bit_err_q} + 25'(popcount(s1_mask_q));

    // NOTE: next-state logic uses blocking '=' and defaults every _d first, so no
    // latch can be inferred on any path.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        s1_valid_d  = accept;
        s1_idx_d    = s1_idx_q;
        s1_mask_d   = s1_mask_q;
        err_count_d = err_count_q;
        bit_err_d   = bit_err_q;
        first_err_d = first_err_q;
        overflow_d  = overflow_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && idx_q == LAST_IDX) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase

        if (accept) begin
            idx_d     = idx_q + ADDR_W'(1);
            s1_idx_d  = idx_q;
            s1_mask_d = resp_data ^ gold_mem[idx_q];
        end

        if (s1_err) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            bit_err_d = bit_sum[24] ? 24'hFFFFFF : bit_sum[23:0];
            if (err_count_q == 16'd0) first_err_d = s1_idx_q;
            if (!push) overflow_d = 1'b1;
        end

        if (push) wr_ptr_d = wr_ptr_q + (LOG_W+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (LOG_W+1)'(1);

        if (run_start) begin
            idx_d       = '0;
            err_count_d = '0;
            bit_err_d   = '0;
            first_err_d = '0;
            overflow_d  = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
        end
    end

    // NOTE: sequential state is updated with non-blocking '<=' only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_mask_q   <= '0;
            err_count_q <= '0;
            bit_err_q   <= '0;
            first_err_q <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            s1_mask_q   <= s1_mask_d;
            err_count_q <= err_count_d;
            bit_err_q   <= bit_err_d;
            first_err_q <= first_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && gold_we && state_q == ST_IDLE) gold_mem[gold_addr] <= gold_data;
        if (!rst && push) log_mem[wr_ptr_q[LOG_W-1:0]] <= {s1_idx_q, s1_mask_q};
    end

    assign head          = log_mem[rd_ptr_q[LOG_W-1:0]];
    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign pass          = done && (err_count_q == 16'd0);
    assign err_count     = err_count_q;
    assign bit_err_count = bit_err_q;
    assign first_err_idx = first_err_q;
    assign log_overflow  = overflow_q;
    assign log_valid     = !fifo_empty;
    // Empty-FIFO head is forced to zero so stale slots never reach the outputs.
    assign log_idx       = fifo_empty ? '0 : head[VEC_WIDTH +: ADDR_W];
    assign log_mask      = fifo_empty ? '0 : head[VEC_WIDTH-1:0];

endmodule

// File: tb/tb_resp_checker.sv
// Directed bench for resp_checker: full-length runs with hand-computed error
// statistics, FIFO logging/overflow, stalls, mid-run reset and restart from DONE.
module tb_resp_checker;

    localparam int VW = 32;
    localparam int VL = 1024;
    localparam int AW = 10;
    localparam int LD = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          gold_we = 1'b0;
    logic [AW-1:0] gold_addr = '0;
    logic [VW-1:0] gold_data = '0;
    logic          start = 1'b0;
    logic          resp_valid = 1'b0;
    logic [VW-1:0] resp_data = '0;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [23:0]   bit_err_count;
    logic [AW-1:0] first_err_idx;
    logic          log_valid;
    logic [AW-1:0] log_idx;
    logic [VW-1:0] log_mask;
    logic          log_ready = 1'b0;
    logic          log_overflow;

    int n_checks = 0;
    int n_errors = 0;
    bit poke_gold = 1'b0;

    always #5 clk = ~clk;

    resp_checker #(.VEC_WIDTH(VW), .VEC_LENGTH(VL), .ADDR_W(AW), .LOG_DEPTH(LD)) dut (
        .clk(clk), .rst(rst),
        .gold_we(gold_we), .gold_addr(gold_addr), .gold_data(gold_data),
        .start(start), .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .bit_err_count(bit_err_count), .first_err_idx(first_err_idx),
        .log_valid(log_valid), .log_idx(log_idx), .log_mask(log_mask),
        .log_ready(log_ready), .log_overflow(log_overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Gold is gold[i] = i; modes: 0 clean, 1 two errors, 2 single bit on 0..19, 3 all bits.
    function automatic logic [31:0] resp_for(input int mode, input int i);
        logic [31:0] g;
        g = 32'(i);
        case (mode)
            1: begin
                if (i == 5)   g = g ^ 32'h3;
                if (i == 700) g = g ^ 32'h8000_0000;
            end
            2: if (i < 20) g = g ^ 32'h1;
            3: g = ~g;
            default: ;
        endcase
        return g;
    endfunction

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stream(input int mode, input bit toggle);
        for (int i = 0; i < VL; i++) begin
            if (toggle) begin
                resp_valid = 1'b0;
                resp_data  = 32'hDEAD_BEEF ^ 32'(i);
                tick();
            end
            resp_valid = 1'b1;
            resp_data  = resp_for(mode, i);
            if (toggle && i == 100) start = 1'b1;
            if (poke_gold && i == 5) begin
                gold_we   = 1'b1;
                gold_addr = 10'd10;
                gold_data = 32'hFFFF_FFFF;
            end
            tick();
            start   = 1'b0;
            gold_we = 1'b0;
            if (toggle && i == 100) check("stray_start_busy", {31'd0, busy}, 32'd1);
            if (mode == 1 && i == 5) check("lat_err_not_yet", {16'd0, err_count}, 32'd0);
            if (mode == 1 && i == 6) begin
                check("lat_err_after2", {16'd0, err_count}, 32'd1);
                check("lat_first_idx", {22'd0, first_err_idx}, 32'd5);
            end
        end
        resp_valid = 1'b0;
        check("drain_not_done", {31'd0, done}, 32'd0);
        check("drain_busy", {31'd0, busy}, 32'd1);
        tick();
        check("done_rise", {31'd0, done}, 32'd1);
        check("done_not_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp_idx, input logic [31:0] exp_mask);
        check({tag, "_valid"}, {31'd0, log_valid}, 32'd1);
        check({tag, "_idx"}, {22'd0, log_idx}, exp_idx);
        check({tag, "_mask"}, log_mask, exp_mask);
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_pass"}, {31'd0, pass}, 32'd0);
        check({tag, "_err"}, {16'd0, err_count}, 32'd0);
        check({tag, "_bits"}, {8'd0, bit_err_count}, 32'd0);
        check({tag, "_first"}, {22'd0, first_err_idx}, 32'd0);
        check({tag, "_lvalid"}, {31'd0, log_valid}, 32'd0);
        check({tag, "_lidx"}, {22'd0, log_idx}, 32'd0);
        check({tag, "_lmask"}, log_mask, 32'd0);
        check({tag, "_ovf"}, {31'd0, log_overflow}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check_zero("reset");

        for (int i = 0; i < VL; i++) begin
            gold_we   = 1'b1;
            gold_addr = AW'(i);
            gold_data = 32'(i);
            tick();
        end
        gold_we = 1'b0;

        // Clean run.
        start_run();
        check("t1_busy", {31'd0, busy}, 32'd1);
        stream(0, 1'b0);
        check("t1_pass", {31'd0, pass}, 32'd1);
        check("t1_err", {16'd0, err_count}, 32'd0);
        check("t1_bits", {8'd0, bit_err_count}, 32'd0);
        check("t1_lvalid", {31'd0, log_valid}, 32'd0);
        repeat (5) tick();
        check("t1_done_hold", {31'd0, done}, 32'd1);

        // Two mismatches, then pop both log entries in DONE.
        start_run();
        stream(1, 1'b0);
        check("t2_err", {16'd0, err_count}, 32'd2);
        check("t2_bits", {8'd0, bit_err_count}, 32'd3);
        check("t2_first", {22'd0, first_err_idx}, 32'd5);
        check("t2_pass", {31'd0, pass}, 32'd0);
        pop_check("t2_pop0", 32'd5, 32'h3);
        pop_check("t2_pop1", 32'd700, 32'h8000_0000);
        check("t2_empty", {31'd0, log_valid}, 32'd0);
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        check("t2_empty_pop_ignored", {31'd0, log_valid}, 32'd0);
        check("t2_err_hold", {16'd0, err_count}, 32'd2);

        // 20 single-bit errors with nobody popping: 16 logged, overflow set.
        start_run();
        stream(2, 1'b0);
        check("t3_err", {16'd0, err_count}, 32'd20);
        check("t3_bits", {8'd0, bit_err_count}, 32'd20);
        check("t3_first", {22'd0, first_err_idx}, 32'd0);
        check("t3_ovf", {31'd0, log_overflow}, 32'd1);
        for (int k = 0; k < LD; k++) pop_check("t3_pop", 32'(k), 32'h1);
        check("t3_empty_after16", {31'd0, log_valid}, 32'd0);

        // Same errors with log_ready held: nothing is dropped.
        log_ready = 1'b1;
        start_run();
        check("t3b_cleared_ovf", {31'd0, log_overflow}, 32'd0);
        stream(2, 1'b0);
        check("t3b_err", {16'd0, err_count}, 32'd20);
        check("t3b_ovf", {31'd0, log_overflow}, 32'd0);
        check("t3b_lvalid", {31'd0, log_valid}, 32'd0);
        log_ready = 1'b0;

        // Alternating valid with garbage on idle cycles and a stray start.
        start_run();
        stream(0, 1'b1);
        check("t4_pass", {31'd0, pass}, 32'd1);
        check("t4_err", {16'd0, err_count}, 32'd0);

        // Abort at vector 300 of an all-bit-error run.
        start_run();
        for (int i = 0; i < 300; i++) begin
            resp_valid = 1'b1;
            resp_data  = resp_for(3, i);
            tick();
        end
        check("t5_pre_err", {16'd0, err_count}, 32'd299);
        check("t5_pre_ovf", {31'd0, log_overflow}, 32'd1);
        rst = 1'b1;
        resp_data = resp_for(3, 300);
        tick();
        rst = 1'b0;
        resp_valid = 1'b0;
        check_zero("t5_rst");
        tick();
        check_zero("t5_idle");
        poke_gold = 1'b1;
        start_run();
        stream(0, 1'b0);
        poke_gold = 1'b0;
        check("t5_rerun_pass", {31'd0, pass}, 32'd1);
        check("t5_rerun_bits", {8'd0, bit_err_count}, 32'd0);

        // Every bit wrong on every vector, then restart from DONE.
        start_run();
        stream(3, 1'b0);
        check("t6_err", {16'd0, err_count}, 32'd1024);
        check("t6_bits", {8'd0, bit_err_count}, 32'd32768);
        check("t6_first", {22'd0, first_err_idx}, 32'd0);
        check("t6_ovf", {31'd0, log_overflow}, 32'd1);
        check("t6_pass", {31'd0, pass}, 32'd0);
        start_run();
        check("t6_restart_busy", {31'd0, busy}, 32'd1);
        check("t6_restart_err", {16'd0, err_count}, 32'd0);
        check("t6_restart_bits", {8'd0, bit_err_count}, 32'd0);
        check("t6_restart_ovf", {31'd0, log_overflow}, 32'd0);
        check("t6_restart_lvalid", {31'd0, log_valid}, 32'd0);
        stream(0, 1'b0);
        check("t6_rerun_pass", {31'd0, pass}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
